function_lut_core: RTL and testbench

- Evaluates a fixed arithmetic function f(x) = x*x for signed fixed-point inputs in two ways: by direct computation and by lookup in a writable table.
- The lookup table is preloaded with f on reset and can be overwritten at runtime to model quantisation or correction entries.
- Compares the two registered results and flags divergence.
- Sits in the datapath as a function-approximation unit that can be verified against its own reference.

---
 rtl/function_lut_core.sv | 69 ++++++
 tb/tb_function_lut_core.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/function_lut_core.sv
// Squares signed fixed-point x two ways, computed directly and looked up in a writable register table.
// Both results are registered and compared; a registered flag reports any divergence.
module function_lut_core #(
  parameter int W_X = 4,
  parameter int W_Y = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic signed [W_X-1:0] xiq,
  input  logic signed [W_Y-1:0] yiq,
  input  logic signed [W_X-1:0] xq,
  input  logic signed [W_X-1:0] xf,
  output logic signed [W_Y-1:0] yf,
  output logic signed [W_Y-1:0] yq_lut,
  output logic signed [W_Y-1:0] yq_fun,
  output logic                  mismatch
);

  localparam int DEPTH = 1 << W_X;
  localparam int PW    = 2 * W_X;
  localparam int CW    = (PW > W_Y) ? PW : W_Y;

  // Square is never negative, so the PW-bit product can be read as unsigned
  // before clamping to the largest positive W_Y value.
  function automatic logic [W_Y-1:0] fsq(input logic signed [W_X-1:0] x);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] p;
    logic [CW-1:0]        pz;
    logic [CW-1:0]        ymax;
    xe = {{W_X{x[W_X-1]}}, x};
    p  = xe * xe;
    pz = '0;
    pz[PW-1:0] = p;
    ymax = '0;
    ymax[W_Y-2:0] = '1;
    if (pz > ymax) return ymax[W_Y-1:0];
    return pz[W_Y-1:0];
  endfunction

  logic [W_Y-1:0] tbl [DEPTH];

  assign yf = fsq(xf);

  // Entry i holds f of the two's-complement reading of i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= fsq(W_X'(i));
      end
    end else if (wr_en) begin
      tbl[$unsigned(xiq)] <= yiq;
    end
  end

  // Read-first: a same-edge write to xq's entry is seen only on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yq_lut   <= '0;
      yq_fun   <= '0;
      mismatch <= 1'b0;
    end else begin
      yq_lut   <= tbl[$unsigned(xq)];
      yq_fun   <= fsq(xq);
      mismatch <= (yq_lut != yq_fun);
    end
  end

endmodule

// File: tb/tb_function_lut_core.sv
// Checks function_lut_core against a table-of-squares model plus a saturating W_X=5 instance.
module tb_function_lut_core;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic signed [3:0] xiq = '0;
  logic signed [7:0] yiq = '0;
  logic signed [3:0] xq = '0;
  logic signed [3:0] xf = '0;
  logic signed [7:0] yf, yq_lut, yq_fun;
  logic              mismatch;

  logic signed [4:0] xq5 = '0;
  logic signed [4:0] xf5 = '0;
  logic signed [7:0] yf5, yq_lut5, yq_fun5;
  logic              mismatch5;

  int tests = 0;
  int failed = 0;

  function_lut_core #(.W_X(4), .W_Y(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .xiq(xiq), .yiq(yiq),
    .xq(xq), .xf(xf), .yf(yf), .yq_lut(yq_lut), .yq_fun(yq_fun), .mismatch(mismatch)
  );

  function_lut_core #(.W_X(5), .W_Y(8)) dut5 (
    .clk(clk), .rst(rst), .wr_en(1'b0), .xiq(5'sd0), .yiq(8'sd0),
    .xq(xq5), .xf(xf5), .yf(yf5), .yq_lut(yq_lut5), .yq_fun(yq_fun5), .mismatch(mismatch5)
  );

  always #5 clk = ~clk;

  // Reference model: a plain array of signed table contents and the expected outputs.
  int mtab[16];
  int m_lut, m_fun, m_mm;

  function automatic int sq(int x);
    int p;
    p = x * x;
    return (p > 127) ? 127 : p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mtab[i] = sq(i >= 8 ? i - 16 : i);
    m_lut = 0;
    m_fun = 0;
    m_mm  = 0;
  endtask

  task automatic check(string nm, int act, int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(int x, bit w, int xi, int yi);
    xq    = 4'(x);
    wr_en = w;
    xiq   = 4'(xi);
    yiq   = 8'(yi);
    @(posedge clk);
    m_mm  = (m_lut != m_fun) ? 1 : 0;
    m_lut = mtab[x & 15];
    m_fun = sq(x);
    if (w) mtab[xi & 15] = yi;
    #1;
    wr_en = 1'b0;
  endtask

  task automatic chk_model(string nm);
    check({nm, "_lut"}, int'(yq_lut), m_lut);
    check({nm, "_fun"}, int'(yq_fun), m_fun);
    check({nm, "_mm"}, int'(mismatch), m_mm);
  endtask

  typedef struct {
    int x;
    int y;
  } vec_t;

  vec_t comb_v[6];
  vec_t sweep_v[16];

  initial begin
    comb_v[0] = '{3, 9};
    comb_v[1] = '{-8, 64};
    comb_v[2] = '{-1, 1};
    comb_v[3] = '{7, 49};
    comb_v[4] = '{0, 0};
    comb_v[5] = '{-5, 25};
    for (int i = 0; i < 16; i++) sweep_v[i] = '{i - 8, (i - 8) * (i - 8)};

    model_reset();
    #1 rst = 1'b1;
    #1;
    foreach (comb_v[i]) begin
      xf = 4'(comb_v[i].x);
      #1;
      check("yf_comb", int'(yf), comb_v[i].y);
    end
    check("rst_lut", int'(yq_lut), 0);
    check("rst_fun", int'(yq_fun), 0);
    check("rst_mm", int'(mismatch), 0);
    xf5 = 5'(-16);
    #1;
    check("yf5_sat", int'(yf5), 127);
    rst = 1'b0;

    // Default table sweep.
    foreach (sweep_v[i]) begin
      step(sweep_v[i].x, 1'b0, 0, 0);
      check("sweep_lut", int'(yq_lut), sweep_v[i].y);
      check("sweep_fun", int'(yq_fun), sweep_v[i].y);
      check("sweep_mm", int'(mismatch), 0);
    end

    // Overwrite entry 3 and watch the divergence come and go.
    step(0, 1'b1, 3, 3);
    step(3, 1'b0, 0, 0);
    check("ovr_lut", int'(yq_lut), 3);
    check("ovr_fun", int'(yq_fun), 9);
    step(2, 1'b0, 0, 0);
    check("ovr_mm_set", int'(mismatch), 1);
    check("ovr2_lut", int'(yq_lut), 4);
    step(2, 1'b0, 0, 0);
    check("ovr_mm_clr", int'(mismatch), 0);

    // Read-first collision.
    step(5, 1'b1, 5, -7);
    check("coll_old", int'(yq_lut), 25);
    step(5, 1'b0, 0, 0);
    check("coll_new", int'(yq_lut), -7);
    chk_model("coll");

    // Async reset between edges, then entry 3 restored.
    step(3, 1'b0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_lut", int'(yq_lut), 0);
    check("arst_fun", int'(yq_fun), 0);
    model_reset();
    #1 rst = 1'b0;
    step(3, 1'b0, 0, 0);
    check("arst_tbl3", int'(yq_lut), 9);
    chk_model("arst");

    // Saturating instance: (-16)^2 = 256 clamps to 127.
    xq5 = 5'(-16);
    @(posedge clk);
    #1;
    check("sat_fun", int'(yq_fun5), 127);
    check("sat_lut", int'(yq_lut5), 127);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(15) - 8, ($urandom_range(3) == 0), $urandom_range(15),
           $urandom_range(255) - 128);
      chk_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
